matmul_tile_scheduler: RTL
==========================

MATMUL_TILE_SCHEDULER -- requirements
Module: matmul_tile_scheduler

Interface
REQ-001 SHALL have parameter TILE, default 8, systolic array edge length in elements.
REQ-002 SHALL have parameter ELEM_BYTES, default 2, bytes per element.
REQ-003 SHALL have parameter DIM_W, default 20, inner-dimension width.
REQ-004 SHALL have parameter TCNT_W, default 12, tile-count width.
REQ-005 SHALL have ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  job request
- cmd_ready  out  1  job accepted
- cmd_act_addr  in  64  activation base address
- cmd_wgt_addr  in  64  weight base address
- cmd_out_addr  in  64  output base address
- cmd_inner_dimension  in  DIM_W  K
- cmd_row_tiles  in  TCNT_W  M/TILE
- cmd_col_tiles  in  TCNT_W  N/TILE
- resp_valid  out  1  job complete
- resp_ready  in  1  completion consumed
- resp_tiles_done  out  2*TCNT_W  tiles executed
- tile_cmd_valid  out  1  tile command to core
- tile_cmd_ready  in  1  core accepts
- tile_cmd_act_addr  out  64  tile activation address
- tile_cmd_wgt_addr  out  64  tile weight address
- tile_cmd_out_addr  out  64  tile output address
- tile_cmd_inner_dimension  out  DIM_W  K, passed through
- tile_resp_valid  in  1  core tile done
- tile_resp_ready  out  1  tile done consumed
- busy  out  1  state != IDLE

Function
REQ-006 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-007 cmd_ready SHALL be 1 only in IDLE; all job fields SHALL be registered on cmd handshake.
REQ-008 On accept, SHALL enter DONE when row_tiles, col_tiles or K is zero, else ISSUE, with tiles_done=0.
REQ-009 In ISSUE, tile_cmd_valid SHALL be 1 with payload stable until tile_cmd_ready; on handshake, SHALL enter WAIT.
REQ-010 In WAIT, tile_resp_ready SHALL be 1; on handshake, SHALL increment tiles_done and enter ISSUE for the next tile or DONE after the last.
REQ-011 Tile order SHALL be row-major: index i over row_tiles (outer), j over col_tiles (inner).
REQ-012 Stride S = K*TILE*ELEM_BYTES SHALL be registered at accept; act addr = act_base + i*S, wgt addr = wgt_base + j*S, out addr = out_base + (i*col_tiles+j)*TILE*TILE*ELEM_BYTES.
REQ-013 Addresses SHALL be updated by incremental adders only (no multipliers); all sums wrap modulo 2^64.
REQ-014 At j wrap, wgt addr SHALL reload wgt_base and act addr SHALL advance by S; out addr SHALL advance by 128 bytes (default parameters) on every tile.
REQ-015 resp_valid SHALL be 1 only in DONE; on resp handshake SHALL return to IDLE.
REQ-016 resp_tiles_done SHALL equal tiles_done, stable while resp_valid.
REQ-017 Latency: cmd accept cycle T gives tile_cmd_valid at T+1; tile_resp handshake at T gives next tile_cmd_valid or resp_valid at T+1.
REQ-018 tile_resp_valid outside WAIT SHALL be ignored and not consumed; cmd_valid outside IDLE SHALL be ignored.
REQ-019 tile_cmd_valid and tile_resp_ready SHALL never be 1 simultaneously.

Reset
REQ-020 Reset SHALL force IDLE, cmd_ready=1 after reset deassertion, all valids, tile_resp_ready and busy 0, counters and addresses 0.
REQ-021 Reset mid-job SHALL abandon the job without resp and issue no further tile commands.

Structure
REQ-022 State encoding, TILE, ELEM_BYTES and tile-byte constant SHALL reside in a shared package tile_sched_pkg.
REQ-023 A sub-module tile_addr_gen (i/j counters plus three address accumulators) SHALL be used; FSM remains in top.

Verification
REQ-024 Job act=0x1000, wgt=0x8000, out=0x20000, K=4, 2x2 tiles, core acks in 1 cycle -> four tile cmds with act/wgt/out (0x1000,0x8000,0x20000), (0x1000,0x8040,0x20080), (0x1040,0x8000,0x20100), (0x1040,0x8040,0x20180); resp with tiles_done=4.
REQ-025 row_tiles=0 -> no tile_cmd_valid; resp_valid one cycle after accept, tiles_done=0.
REQ-026 tile_cmd_ready held 0 for 5 cycles -> tile_cmd_valid and payload stable throughout; one tile issued.
REQ-027 act_base=0xFFFF_FFFF_FFFF_FFF0, K=1, 2x1 tiles -> second tile act addr 0x0000_0000_0000_0000.
REQ-028 Reset asserted in WAIT of tile 2 of 4 -> IDLE next cycle, no resp; new 1x1 job then completes with tiles_done=1.
REQ-029 Spurious tile_resp_valid during ISSUE and resp_ready held 0 for 3 cycles in DONE -> tile_resp_ready stays 0 in ISSUE; resp_valid and tiles_done held.

Source files
------------

// File: rtl/tile_sched_pkg.sv
// Shared definitions for the matmul tile scheduler: FSM encoding and
// default tile geometry constants.
package tile_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  localparam int TILE_EDGE  = 8;
  localparam int ELEM_SIZE  = 2;
  localparam int TILE_BYTES = TILE_EDGE * TILE_EDGE * ELEM_SIZE;

  // Byte footprint of one output tile for arbitrary geometry.
  function automatic logic [63:0] tile_bytes(input int tile, input int elem_bytes);
    return 64'(tile * tile * elem_bytes);
  endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Row-major (i outer, j inner) tile walker producing activation, weight and
// output addresses with running accumulators only.
module tile_addr_gen
  import tile_sched_pkg::*;
#(
  parameter int TILE       = TILE_EDGE,
  parameter int ELEM_BYTES = ELEM_SIZE,
  parameter int DIM_W      = 20,
  parameter int TCNT_W     = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [63:0]       act_base,
  input  logic [63:0]       wgt_base,
  input  logic [63:0]       out_base,
  input  logic [DIM_W-1:0]  inner_dimension,
  input  logic [TCNT_W-1:0] row_tiles,
  input  logic [TCNT_W-1:0] col_tiles,
  output logic [63:0]       act_addr,
  output logic [63:0]       wgt_addr,
  output logic [63:0]       out_addr,
  output logic              last_tile
);

  localparam logic [63:0] ROW_BYTES  = 64'(TILE * ELEM_BYTES);
  localparam logic [63:0] OUT_STRIDE = tile_bytes(TILE, ELEM_BYTES);

  logic [TCNT_W-1:0] i_reg;
  logic [TCNT_W-1:0] j_reg;
  logic [TCNT_W-1:0] row_last_reg;
  logic [TCNT_W-1:0] col_last_reg;
  logic [63:0]       act_reg;
  logic [63:0]       wgt_reg;
  logic [63:0]       out_reg;
  logic [63:0]       wgt_base_reg;
  logic [63:0]       stride_reg;
  logic              col_wrap;

  assign col_wrap  = (j_reg == col_last_reg);
  assign last_tile = (i_reg == row_last_reg) && col_wrap;

  always_ff @(posedge clock) begin
    if (reset) begin
      i_reg        <= '0;
      j_reg        <= '0;
      row_last_reg <= '0;
      col_last_reg <= '0;
      act_reg      <= '0;
      wgt_reg      <= '0;
      out_reg      <= '0;
      wgt_base_reg <= '0;
      stride_reg   <= '0;
    end else if (load) begin
      i_reg        <= '0;
      j_reg        <= '0;
      row_last_reg <= row_tiles - 1'b1;
      col_last_reg <= col_tiles - 1'b1;
      act_reg      <= act_base;
      wgt_reg      <= wgt_base;
      out_reg      <= out_base;
      wgt_base_reg <= wgt_base;
      // Constant scale by TILE*ELEM_BYTES, done once per job.
      stride_reg   <= 64'(inner_dimension) * ROW_BYTES;
    end else if (step) begin
      out_reg <= out_reg + OUT_STRIDE;
      if (col_wrap) begin
        j_reg   <= '0;
        i_reg   <= i_reg + 1'b1;
        wgt_reg <= wgt_base_reg;
        act_reg <= act_reg + stride_reg;
      end else begin
        j_reg   <= j_reg + 1'b1;
        wgt_reg <= wgt_reg + stride_reg;
      end
    end
  end

  assign act_addr = act_reg;
  assign wgt_addr = wgt_reg;
  assign out_addr = out_reg;

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Job-level scheduler: accepts a matmul job, issues one tile command at a
// time to the systolic core, and reports completion with a tile count.
module matmul_tile_scheduler
  import tile_sched_pkg::*;
#(
  parameter int TILE       = TILE_EDGE,
  parameter int ELEM_BYTES = ELEM_SIZE,
  parameter int DIM_W      = 20,
  parameter int TCNT_W     = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [63:0]         cmd_act_addr,
  input  logic [63:0]         cmd_wgt_addr,
  input  logic [63:0]         cmd_out_addr,
  input  logic [DIM_W-1:0]    cmd_inner_dimension,
  input  logic [TCNT_W-1:0]   cmd_row_tiles,
  input  logic [TCNT_W-1:0]   cmd_col_tiles,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [2*TCNT_W-1:0] resp_tiles_done,
  output logic                tile_cmd_valid,
  input  logic                tile_cmd_ready,
  output logic [63:0]         tile_cmd_act_addr,
  output logic [63:0]         tile_cmd_wgt_addr,
  output logic [63:0]         tile_cmd_out_addr,
  output logic [DIM_W-1:0]    tile_cmd_inner_dimension,
  input  logic                tile_resp_valid,
  output logic                tile_resp_ready,
  output logic                busy
);

  sched_state_t        state_reg;
  sched_state_t        state_next;
  logic [DIM_W-1:0]    k_reg;
  logic [2*TCNT_W-1:0] tiles_done_reg;
  logic                accept;
  logic                tile_done;
  logic                last_tile;
  logic                empty_job;

  assign accept    = (state_reg == IDLE) && cmd_valid;
  assign tile_done = (state_reg == WAIT) && tile_resp_valid;
  assign empty_job = (cmd_row_tiles == '0) || (cmd_col_tiles == '0) ||
                     (cmd_inner_dimension == '0);

  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      k_reg          <= '0;
      tiles_done_reg <= '0;
    end else if (accept) begin
      k_reg          <= cmd_inner_dimension;
      tiles_done_reg <= '0;
    end else if (tile_done) begin
      tiles_done_reg <= tiles_done_reg + 1'b1;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cmd_ready       = 1'b0;
    tile_cmd_valid  = 1'b0;
    tile_resp_ready = 1'b0;
    resp_valid      = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = empty_job ? DONE : ISSUE;
      end
      ISSUE: begin
        tile_cmd_valid = 1'b1;
        if (tile_cmd_ready) state_next = WAIT;
      end
      WAIT: begin
        tile_resp_ready = 1'b1;
        if (tile_resp_valid) state_next = last_tile ? DONE : ISSUE;
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  tile_addr_gen #(
    .TILE       (TILE),
    .ELEM_BYTES (ELEM_BYTES),
    .DIM_W      (DIM_W),
    .TCNT_W     (TCNT_W)
  ) u_addr_gen (
    .clock           (clock),
    .reset           (reset),
    .load            (accept),
    .step            (tile_done),
    .act_base        (cmd_act_addr),
    .wgt_base        (cmd_wgt_addr),
    .out_base        (cmd_out_addr),
    .inner_dimension (cmd_inner_dimension),
    .row_tiles       (cmd_row_tiles),
    .col_tiles       (cmd_col_tiles),
    .act_addr        (tile_cmd_act_addr),
    .wgt_addr        (tile_cmd_wgt_addr),
    .out_addr        (tile_cmd_out_addr),
    .last_tile       (last_tile)
  );

  assign tile_cmd_inner_dimension = k_reg;
  assign resp_tiles_done          = tiles_done_reg;
  assign busy                     = (state_reg != IDLE);

endmodule
